mem_port_arbiter: RTL and testbench

Arbitrates the single unified memory port between the fetch stage (read-only) and the memory stage (loads and stores). It sits between the pipeline and the memory model/controller, with one transaction outstanding at a time. Requests are granted round-robin and latched into a registered issue path. Each response is routed back only to the requester that owns the transaction.

---
 rtl/mem_port_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shared-memory-port arbiter: round-robin between the fetch stage and the memory
// stage, one outstanding transaction, with responses routed back to the owning requester.
package params_pkg;
    parameter int ADDR_WIDTH = 32;
    parameter int DATA_WIDTH = 32;
    typedef enum logic [1:0] {BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2} access_size_t;
endpackage

module mem_port_arbiter #(
    parameter int ADDR_WIDTH = params_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = params_pkg::DATA_WIDTH
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     if_req_valid_i,
    input  logic [ADDR_WIDTH-1:0]    if_req_addr_i,
    output logic                     if_req_ready_o,
    output logic                     if_resp_valid_o,
    output logic [DATA_WIDTH-1:0]    if_resp_data_o,
    input  logic                     dm_rd_req_valid_i,
    input  logic                     dm_wr_req_valid_i,
    input  logic [ADDR_WIDTH-1:0]    dm_req_addr_i,
    input  logic [DATA_WIDTH-1:0]    dm_wr_data_i,
    input  logic [3:0]               dm_wr_strb_i,
    input  params_pkg::access_size_t dm_access_size_i,
    output logic                     dm_req_ready_o,
    output logic                     dm_resp_valid_o,
    output logic [DATA_WIDTH-1:0]    dm_resp_data_o,
    output logic                     mem_req_valid_o,
    input  logic                     mem_req_ready_i,
    output logic                     mem_req_we_o,
    output logic [ADDR_WIDTH-1:0]    mem_req_addr_o,
    output logic [DATA_WIDTH-1:0]    mem_wr_data_o,
    output logic [3:0]               mem_wr_strb_o,
    output params_pkg::access_size_t mem_access_size_o,
    input  logic                     mem_resp_valid_i,
    input  logic [DATA_WIDTH-1:0]    mem_resp_data_i
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_t;
    typedef enum logic {REQ_FETCH, REQ_DATA} requester_t;

    state_t                   state_q, state_d;
    requester_t               last_grant_q, last_grant_d;
    requester_t               owner_q, owner_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic                     we_q, we_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [3:0]               strb_q, strb_d;
    params_pkg::access_size_t size_q, size_d;
    logic                     if_resp_valid_q, if_resp_valid_d;
    logic [DATA_WIDTH-1:0]    if_resp_data_q, if_resp_data_d;
    logic                     dm_resp_valid_q, dm_resp_valid_d;
    logic [DATA_WIDTH-1:0]    dm_resp_data_q, dm_resp_data_d;
    logic                     grant_if, grant_dm;
    logic                     dm_pending;

    always_comb begin
        state_d         = state_q;
        last_grant_d    = last_grant_q;
        owner_d         = owner_q;
        addr_d          = addr_q;
        we_d            = we_q;
        wdata_d         = wdata_q;
        strb_d          = strb_q;
        size_d          = size_q;
        if_resp_valid_d = 1'b0;
        if_resp_data_d  = if_resp_data_q;
        dm_resp_valid_d = 1'b0;
        dm_resp_data_d  = dm_resp_data_q;
        grant_if        = 1'b0;
        grant_dm        = 1'b0;
        dm_pending      = dm_rd_req_valid_i | dm_wr_req_valid_i;

        case (state_q)
            IDLE: begin
                // Ready is combinational, so it is held off while reset is asserted.
                if (!rst_i) begin
                    grant_dm = dm_pending && (!if_req_valid_i || last_grant_q == REQ_FETCH);
                    grant_if = if_req_valid_i && !grant_dm;
                end
                if (grant_dm) begin
                    owner_d      = REQ_DATA;
                    last_grant_d = REQ_DATA;
                    addr_d       = dm_req_addr_i;
                    we_d         = dm_wr_req_valid_i;
                    wdata_d      = dm_wr_data_i;
                    strb_d       = dm_wr_strb_i;
                    size_d       = dm_access_size_i;
                    state_d      = ISSUE;
                end else if (grant_if) begin
                    owner_d      = REQ_FETCH;
                    last_grant_d = REQ_FETCH;
                    addr_d       = if_req_addr_i;
                    we_d         = 1'b0;
                    wdata_d      = '0;
                    strb_d       = 4'b0000;
                    size_d       = params_pkg::WORD;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_req_ready_i) begin
                    if (we_q) begin
                        dm_resp_valid_d = 1'b1;
                        dm_resp_data_d  = '0;
                        state_d         = IDLE;
                    end else begin
                        state_d = WAIT_RESP;
                    end
                end
            end
            WAIT_RESP: begin
                if (mem_resp_valid_i) begin
                    if (owner_q == REQ_FETCH) begin
                        if_resp_valid_d = 1'b1;
                        if_resp_data_d  = mem_resp_data_i;
                    end else begin
                        dm_resp_valid_d = 1'b1;
                        dm_resp_data_d  = mem_resp_data_i;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= IDLE;
            last_grant_q    <= REQ_FETCH;
            owner_q         <= REQ_FETCH;
            addr_q          <= '0;
            we_q            <= 1'b0;
            wdata_q         <= '0;
            strb_q          <= 4'b0000;
            size_q          <= params_pkg::BYTE;
            if_resp_valid_q <= 1'b0;
            if_resp_data_q  <= '0;
            dm_resp_valid_q <= 1'b0;
            dm_resp_data_q  <= '0;
        end else begin
            state_q         <= state_d;
            last_grant_q    <= last_grant_d;
            owner_q         <= owner_d;
            addr_q          <= addr_d;
            we_q            <= we_d;
            wdata_q         <= wdata_d;
            strb_q          <= strb_d;
            size_q          <= size_d;
            if_resp_valid_q <= if_resp_valid_d;
            if_resp_data_q  <= if_resp_data_d;
            dm_resp_valid_q <= dm_resp_valid_d;
            dm_resp_data_q  <= dm_resp_data_d;
        end
    end

    assign if_req_ready_o    = grant_if;
    assign dm_req_ready_o    = grant_dm;
    assign mem_req_valid_o   = (state_q == ISSUE);
    assign mem_req_we_o      = we_q;
    assign mem_req_addr_o    = addr_q;
    assign mem_wr_data_o     = wdata_q;
    assign mem_wr_strb_o     = strb_q;
    assign mem_access_size_o = size_q;
    assign if_resp_valid_o   = if_resp_valid_q;
    assign if_resp_data_o    = if_resp_data_q;
    assign dm_resp_valid_o   = dm_resp_valid_q;
    assign dm_resp_data_o    = dm_resp_data_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a cycle table for round-robin ties plus
// hand-written sequences for fetch, store, spurious responses, reset and illegal requests.
module tb_mem_port_arbiter;
    logic                     clk_i = 1'b0;
    logic                     rst_i = 1'b1;
    logic                     if_req_valid_i = 1'b0;
    logic [31:0]              if_req_addr_i = '0;
    logic                     if_req_ready_o;
    logic                     if_resp_valid_o;
    logic [31:0]              if_resp_data_o;
    logic                     dm_rd_req_valid_i = 1'b0;
    logic                     dm_wr_req_valid_i = 1'b0;
    logic [31:0]              dm_req_addr_i = '0;
    logic [31:0]              dm_wr_data_i = '0;
    logic [3:0]               dm_wr_strb_i = '0;
    params_pkg::access_size_t dm_access_size_i = params_pkg::WORD;
    logic                     dm_req_ready_o;
    logic                     dm_resp_valid_o;
    logic [31:0]              dm_resp_data_o;
    logic                     mem_req_valid_o;
    logic                     mem_req_ready_i = 1'b0;
    logic                     mem_req_we_o;
    logic [31:0]              mem_req_addr_o;
    logic [31:0]              mem_wr_data_o;
    logic [3:0]               mem_wr_strb_o;
    params_pkg::access_size_t mem_access_size_o;
    logic                     mem_resp_valid_i = 1'b0;
    logic [31:0]              mem_resp_data_i = '0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        if_v;
        logic        dm_rd;
        logic        dm_wr;
        logic        mready;
        logic        mresp_v;
        logic [31:0] mresp_data;
        logic        exp_if_ready;
        logic        exp_dm_ready;
        logic        exp_mvalid;
        logic        exp_we;
        logic [31:0] exp_addr;
        logic        exp_if_rv;
        logic        exp_dm_rv;
        logic [31:0] exp_if_rd;
        logic [31:0] exp_dm_rd;
    } vec_t;

    vec_t vectors [11];

    mem_port_arbiter dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_req_valid_i(if_req_valid_i), .if_req_addr_i(if_req_addr_i),
        .if_req_ready_o(if_req_ready_o), .if_resp_valid_o(if_resp_valid_o),
        .if_resp_data_o(if_resp_data_o),
        .dm_rd_req_valid_i(dm_rd_req_valid_i), .dm_wr_req_valid_i(dm_wr_req_valid_i),
        .dm_req_addr_i(dm_req_addr_i), .dm_wr_data_i(dm_wr_data_i),
        .dm_wr_strb_i(dm_wr_strb_i), .dm_access_size_i(dm_access_size_i),
        .dm_req_ready_o(dm_req_ready_o), .dm_resp_valid_o(dm_resp_valid_o),
        .dm_resp_data_o(dm_resp_data_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_req_we_o(mem_req_we_o), .mem_req_addr_o(mem_req_addr_o),
        .mem_wr_data_o(mem_wr_data_o), .mem_wr_strb_o(mem_wr_strb_o),
        .mem_access_size_o(mem_access_size_o),
        .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_data_i(mem_resp_data_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        if_req_valid_i    = v.if_v;
        dm_rd_req_valid_i = v.dm_rd;
        dm_wr_req_valid_i = v.dm_wr;
        mem_req_ready_i   = v.mready;
        mem_resp_valid_i  = v.mresp_v;
        mem_resp_data_i   = v.mresp_data;
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        if_req_valid_i    = 1'b0;
        if_req_addr_i     = '0;
        dm_rd_req_valid_i = 1'b0;
        dm_wr_req_valid_i = 1'b0;
        dm_req_addr_i     = '0;
        dm_wr_data_i      = '0;
        dm_wr_strb_i      = '0;
        dm_access_size_i  = params_pkg::WORD;
        mem_req_ready_i   = 1'b0;
        mem_resp_valid_i  = 1'b0;
        mem_resp_data_i   = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_i = 1'b1;
        next_cycle();
        next_cycle();
        rst_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vectors[0]  = '{1,1,0,1,0,32'h0,        0,1,0,0,32'h00, 0,0,32'h0,        32'h0};
        vectors[1]  = '{1,1,0,1,0,32'h0,        0,0,1,0,32'h80, 0,0,32'h0,        32'h0};
        vectors[2]  = '{1,1,0,1,1,32'h11111111, 0,0,0,0,32'h80, 0,0,32'h0,        32'h0};
        vectors[3]  = '{1,1,0,1,0,32'h0,        1,0,0,0,32'h80, 0,1,32'h0,        32'h11111111};
        vectors[4]  = '{1,1,0,1,0,32'h0,        0,0,1,0,32'h40, 0,0,32'h0,        32'h11111111};
        vectors[5]  = '{1,1,0,1,1,32'h22222222, 0,0,0,0,32'h40, 0,0,32'h0,        32'h11111111};
        vectors[6]  = '{1,1,0,1,0,32'h0,        0,1,0,0,32'h40, 1,0,32'h22222222, 32'h11111111};
        vectors[7]  = '{1,1,0,1,0,32'h0,        0,0,1,0,32'h80, 0,0,32'h22222222, 32'h11111111};
        vectors[8]  = '{1,1,0,1,1,32'h33333333, 0,0,0,0,32'h80, 0,0,32'h22222222, 32'h11111111};
        vectors[9]  = '{1,1,0,1,0,32'h0,        1,0,0,0,32'h80, 0,1,32'h22222222, 32'h33333333};
        vectors[10] = '{1,1,0,1,0,32'h0,        0,0,1,0,32'h40, 0,0,32'h22222222, 32'h33333333};

        // Reset state: every output low.
        do_reset();
        @(negedge clk_i);
        checkOutput("rst_if_ready", 32'(if_req_ready_o), 0);
        checkOutput("rst_dm_ready", 32'(dm_req_ready_o), 0);
        checkOutput("rst_mem_valid", 32'(mem_req_valid_o), 0);
        checkOutput("rst_mem_addr", mem_req_addr_o, 0);
        checkOutput("rst_if_resp_valid", 32'(if_resp_valid_o), 0);
        checkOutput("rst_dm_resp_valid", 32'(dm_resp_valid_o), 0);

        // Round-robin table: both requesters always pending.
        do_reset();
        if_req_addr_i = 32'h40;
        dm_req_addr_i = 32'h80;
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vectors[i]);
            @(negedge clk_i);
            checkOutput($sformatf("rr%0d_if_ready", i), 32'(if_req_ready_o), 32'(vectors[i].exp_if_ready));
            checkOutput($sformatf("rr%0d_dm_ready", i), 32'(dm_req_ready_o), 32'(vectors[i].exp_dm_ready));
            checkOutput($sformatf("rr%0d_mem_valid", i), 32'(mem_req_valid_o), 32'(vectors[i].exp_mvalid));
            checkOutput($sformatf("rr%0d_mem_we", i), 32'(mem_req_we_o), 32'(vectors[i].exp_we));
            checkOutput($sformatf("rr%0d_mem_addr", i), mem_req_addr_o, vectors[i].exp_addr);
            checkOutput($sformatf("rr%0d_if_resp_valid", i), 32'(if_resp_valid_o), 32'(vectors[i].exp_if_rv));
            checkOutput($sformatf("rr%0d_dm_resp_valid", i), 32'(dm_resp_valid_o), 32'(vectors[i].exp_dm_rv));
            checkOutput($sformatf("rr%0d_if_resp_data", i), if_resp_data_o, vectors[i].exp_if_rd);
            checkOutput($sformatf("rr%0d_dm_resp_data", i), dm_resp_data_o, vectors[i].exp_dm_rd);
            next_cycle();
        end

        // Fetch-only read of 0x40.
        do_reset();
        if_req_valid_i = 1'b1;
        if_req_addr_i  = 32'h40;
        @(negedge clk_i);
        checkOutput("fe_if_ready", 32'(if_req_ready_o), 1);
        checkOutput("fe_dm_ready", 32'(dm_req_ready_o), 0);
        checkOutput("fe_mem_valid_t0", 32'(mem_req_valid_o), 0);
        next_cycle();
        if_req_valid_i  = 1'b0;
        if_req_addr_i   = 32'h999;
        mem_req_ready_i = 1'b1;
        @(negedge clk_i);
        checkOutput("fe_mem_valid_t1", 32'(mem_req_valid_o), 1);
        checkOutput("fe_mem_addr", mem_req_addr_o, 32'h40);
        checkOutput("fe_mem_we", 32'(mem_req_we_o), 0);
        checkOutput("fe_mem_strb", 32'(mem_wr_strb_o), 0);
        checkOutput("fe_mem_size", 32'(mem_access_size_o), 32'(params_pkg::WORD));
        next_cycle();
        mem_req_ready_i  = 1'b0;
        mem_resp_valid_i = 1'b1;
        mem_resp_data_i  = 32'hDEADBEEF;
        @(negedge clk_i);
        checkOutput("fe_mem_valid_wait", 32'(mem_req_valid_o), 0);
        next_cycle();
        mem_resp_valid_i = 1'b0;
        mem_resp_data_i  = 32'h0;
        @(negedge clk_i);
        checkOutput("fe_if_resp_valid", 32'(if_resp_valid_o), 1);
        checkOutput("fe_if_resp_data", if_resp_data_o, 32'hDEADBEEF);
        checkOutput("fe_dm_resp_valid", 32'(dm_resp_valid_o), 0);
        next_cycle();
        @(negedge clk_i);
        checkOutput("fe_if_resp_valid_drop", 32'(if_resp_valid_o), 0);
        checkOutput("fe_if_resp_data_hold", if_resp_data_o, 32'hDEADBEEF);

        // Byte store held off by memory for three cycles.
        do_reset();
        dm_wr_req_valid_i = 1'b1;
        dm_req_addr_i     = 32'h103;
        dm_wr_strb_i      = 4'b1000;
        dm_access_size_i  = params_pkg::BYTE;
        dm_wr_data_i      = 32'h000000AA;
        @(negedge clk_i);
        checkOutput("st_dm_ready", 32'(dm_req_ready_o), 1);
        next_cycle();
        dm_wr_req_valid_i = 1'b0;
        dm_req_addr_i     = 32'hFFF;
        dm_wr_data_i      = 32'h55;
        dm_wr_strb_i      = 4'b0001;
        for (int c = 0; c < 4; c++) begin
            mem_req_ready_i = (c == 3);
            @(negedge clk_i);
            checkOutput($sformatf("st%0d_mem_valid", c), 32'(mem_req_valid_o), 1);
            checkOutput($sformatf("st%0d_mem_we", c), 32'(mem_req_we_o), 1);
            checkOutput($sformatf("st%0d_mem_addr", c), mem_req_addr_o, 32'h103);
            checkOutput($sformatf("st%0d_mem_data", c), mem_wr_data_o, 32'hAA);
            checkOutput($sformatf("st%0d_mem_strb", c), 32'(mem_wr_strb_o), 32'h8);
            checkOutput($sformatf("st%0d_mem_size", c), 32'(mem_access_size_o), 32'(params_pkg::BYTE));
            checkOutput($sformatf("st%0d_dm_resp_valid", c), 32'(dm_resp_valid_o), 0);
            next_cycle();
        end
        mem_req_ready_i = 1'b0;
        if_req_valid_i  = 1'b1;
        @(negedge clk_i);
        checkOutput("st_done_mem_valid", 32'(mem_req_valid_o), 0);
        checkOutput("st_done_dm_resp_valid", 32'(dm_resp_valid_o), 1);
        checkOutput("st_done_dm_resp_data", dm_resp_data_o, 0);
        checkOutput("st_done_if_ready", 32'(if_req_ready_o), 1);
        next_cycle();
        if_req_valid_i = 1'b0;
        @(negedge clk_i);
        checkOutput("st_single_pulse", 32'(dm_resp_valid_o), 0);

        // Spurious memory responses in IDLE and ISSUE are ignored.
        do_reset();
        mem_resp_valid_i = 1'b1;
        mem_resp_data_i  = 32'hBAD0BAD0;
        next_cycle();
        if_req_valid_i = 1'b1;
        if_req_addr_i  = 32'h44;
        @(negedge clk_i);
        checkOutput("sp_idle_if_rv", 32'(if_resp_valid_o), 0);
        checkOutput("sp_idle_dm_rv", 32'(dm_resp_valid_o), 0);
        next_cycle();
        if_req_valid_i = 1'b0;
        next_cycle();
        mem_req_ready_i  = 1'b1;
        mem_resp_valid_i = 1'b0;
        @(negedge clk_i);
        checkOutput("sp_issue_if_rv", 32'(if_resp_valid_o), 0);
        checkOutput("sp_issue_dm_rv", 32'(dm_resp_valid_o), 0);
        checkOutput("sp_issue_mem_valid", 32'(mem_req_valid_o), 1);
        next_cycle();
        mem_req_ready_i = 1'b0;
        @(negedge clk_i);
        checkOutput("sp_wait_if_rv", 32'(if_resp_valid_o), 0);
        checkOutput("sp_if_data", if_resp_data_o, 0);

        // Reset while waiting for a load response.
        do_reset();
        dm_rd_req_valid_i = 1'b1;
        dm_req_addr_i     = 32'h80;
        mem_req_ready_i   = 1'b1;
        next_cycle();
        dm_rd_req_valid_i = 1'b0;
        next_cycle();
        mem_req_ready_i   = 1'b0;
        if_req_valid_i    = 1'b1;
        dm_rd_req_valid_i = 1'b1;
        rst_i             = 1'b1;
        @(negedge clk_i);
        checkOutput("mr_if_ready", 32'(if_req_ready_o), 0);
        checkOutput("mr_dm_ready", 32'(dm_req_ready_o), 0);
        checkOutput("mr_mem_valid", 32'(mem_req_valid_o), 0);
        checkOutput("mr_mem_addr", mem_req_addr_o, 0);
        checkOutput("mr_dm_rv", 32'(dm_resp_valid_o), 0);
        next_cycle();
        rst_i            = 1'b0;
        mem_resp_valid_i = 1'b1;
        mem_resp_data_i  = 32'hCAFEF00D;
        @(negedge clk_i);
        checkOutput("mr_tie_dm_ready", 32'(dm_req_ready_o), 1);
        checkOutput("mr_tie_if_ready", 32'(if_req_ready_o), 0);
        next_cycle();
        if_req_valid_i    = 1'b0;
        dm_rd_req_valid_i = 1'b0;
        @(negedge clk_i);
        checkOutput("mr_late_dm_rv", 32'(dm_resp_valid_o), 0);
        checkOutput("mr_late_if_rv", 32'(if_resp_valid_o), 0);
        checkOutput("mr_late_dm_data", dm_resp_data_o, 0);

        // Simultaneous load and store request issues only the store.
        do_reset();
        dm_rd_req_valid_i = 1'b1;
        dm_wr_req_valid_i = 1'b1;
        dm_req_addr_i     = 32'h200;
        dm_wr_data_i      = 32'h1234;
        dm_wr_strb_i      = 4'hF;
        mem_req_ready_i   = 1'b1;
        @(negedge clk_i);
        checkOutput("il_dm_ready", 32'(dm_req_ready_o), 1);
        next_cycle();
        dm_rd_req_valid_i = 1'b0;
        dm_wr_req_valid_i = 1'b0;
        @(negedge clk_i);
        checkOutput("il_mem_valid", 32'(mem_req_valid_o), 1);
        checkOutput("il_mem_we", 32'(mem_req_we_o), 1);
        checkOutput("il_mem_data", mem_wr_data_o, 32'h1234);
        next_cycle();
        @(negedge clk_i);
        checkOutput("il_dm_rv", 32'(dm_resp_valid_o), 1);
        checkOutput("il_mem_valid_after", 32'(mem_req_valid_o), 0);
        checkOutput("il_no_second_ready", 32'(dm_req_ready_o), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
